// File: rtl/pipe_pkg.sv
// Shared constants and types for the generic inter-stage pipeline register.
package pipe_pkg;

    localparam int          FW_DEFAULT = 32;
    localparam logic [31:0] NOP_IR     = 32'h0;

    // Field slots in the packed in_data/out_data bus
    localparam int F_IR  = 0;
    localparam int F_PC4 = 1;
    localparam int F_RD2 = 2;
    localparam int F_AO  = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_perf_ctr.sv
// 32-bit enable-increment event counter with synchronous clear; wraps mod 2^32.
module pipe_perf_ctr (
    input  logic        CLK,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge CLK) begin
        if (clear)
            count <= 32'd0;
        else if (en)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register with flush; in_ready is a flop.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_stage_skid #(
    parameter int                     NFIELDS = 4,
    parameter int                     FW      = pipe_pkg::FW_DEFAULT,
    parameter logic [FW-1:0]          NOP_IR  = FW'(pipe_pkg::NOP_IR)
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NFIELDS*FW-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NFIELDS*FW-1:0]     out_data,
    output logic [1:0]                occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt
`endif
);

    import pipe_pkg::*;

    localparam int W = NFIELDS * FW;
    // NOP in field 0, every other field zero
    localparam logic [W-1:0] BUBBLE = W'(NOP_IR);

    // Handshake: a transfer happens on a rising CLK edge where valid and ready
    // are both high; valid never waits on ready, and in_ready depends only on
    // registered state so out_ready has no combinational path to in_ready.

    state_t         st;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;
    logic           ready_q;
    logic           in_fire;
    logic           out_fire;

    assign in_ready  = ready_q;
    assign out_valid = (st != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = st;
    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            st      <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            case (st)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        st     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q  <= in_data;
                        st      <= ST_TWO;
                        ready_q <= 1'b0;
                    end else if (out_fire) begin
                        main_q <= BUBBLE;
                        st     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // skid always drains into main, so order stays FIFO
                    if (out_fire) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        st      <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    st      <= ST_EMPTY;
                    main_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counters ignore flush; only reset clears them
    pipe_perf_ctr u_stall_ctr (
        .CLK   (CLK),
        .clear (reset),
        .en    (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_perf_ctr u_bubble_ctr (
        .CLK   (CLK),
        .clear (reset),
        .en    (~out_valid),
        .count (bubble_cnt)
    );
`else
    // Counters compiled out; datapath is unaffected.
`endif

endmodule
